calc_sequencer: RTL and testbench

- Control FSM for the calculator datapath.
- Accepts one-cycle keypad event pulses (digit, operator, equals, clear) and issues one-cycle load/shift strobes to the V1/V2 operand registers.
- Latches the pending operator and runs a start/done handshake with the multi-cycle arithmetic unit.
- Tracks digit count, operator chaining and error state; sits between the keypad decoder and the register/arithmetic/display blocks.

---
 rtl/calc_sequencer_pkg.sv | 24 ++
 rtl/calc_sequencer_if.sv | 38 +++
 rtl/calc_sequencer_watchdog.sv | 32 +++
 rtl/calc_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_sequencer_pkg.sv
// Shared types and defaults for the calculator control sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        SHOW   = 3'd0,
        ENTRY  = 3'd1,
        OPWAIT = 3'd2,
        CALC   = 3'd3,
        CHAIN  = 3'd4,
        ERR    = 3'd5
    } state_t;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'd0;
    localparam op_t OP_SUB = 2'd1;
    localparam op_t OP_MUL = 2'd2;
    localparam op_t OP_AND = 2'd3;

    localparam int DEF_MAX_DIGITS  = 4;
    localparam int DEF_ALU_TIMEOUT = 64;
    localparam int DEF_CNT_W       = 7;

endpackage

// File: rtl/calc_sequencer_if.sv
// Keypad-event, register-strobe and ALU handshake bundle of the sequencer.
interface calc_sequencer_if;
    import calc_pkg::*;

    logic       newhex;
    logic [3:0] hexcode;
    logic       newop;
    op_t        opcode;
    logic       eq;
    logic       clr;
    logic       alu_done;
    logic       alu_ovf;

    logic       v1_shift;
    logic       v1_overwrite;
    logic       v1_load_ans;
    logic       v2_load;
    logic       regs_clear;
    logic [3:0] hex_out;
    logic       alu_start;
    op_t        alu_op;
    logic       busy;
    logic       error;
    logic [2:0] digit_cnt;

    modport master (
        output newhex, hexcode, newop, opcode, eq, clr, alu_done, alu_ovf,
        input  v1_shift, v1_overwrite, v1_load_ans, v2_load, regs_clear,
               hex_out, alu_start, alu_op, busy, error, digit_cnt
    );

    modport slave (
        input  newhex, hexcode, newop, opcode, eq, clr, alu_done, alu_ovf,
        output v1_shift, v1_overwrite, v1_load_ans, v2_load, regs_clear,
               hex_out, alu_start, alu_op, busy, error, digit_cnt
    );

endinterface

// File: rtl/calc_sequencer_watchdog.sv
// ALU watchdog: loaded when an operation starts, counts down while waiting.
module calc_watchdog #(
    parameter int CNT_W       = 7,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ALU_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Reload on alu_start, then count each cycle spent waiting for the ALU.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    // Last waiting cycle: the timeout takes effect at the next edge.
    assign o_expired = i_run && (r_cnt == ONE);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: turns keypad pulses into operand-register strobes
// and runs the start/done handshake with the multi-cycle ALU.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS  = DEF_MAX_DIGITS,
    parameter int ALU_TIMEOUT = DEF_ALU_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    calc_sequencer_if.slave  bus
);

    localparam logic [2:0] MAXD = 3'(MAX_DIGITS);

    state_t     r_state,       w_nxt_state;
    op_t        r_pend_op,     w_nxt_pend_op;
    logic       r_pend_valid,  w_nxt_pend_valid;
    op_t        r_chain_op,    w_nxt_chain_op;
    logic       r_chain_valid, w_nxt_chain_valid;
    logic [2:0] r_digit_cnt,   w_nxt_digit_cnt;
    logic       r_v1_shift,    w_nxt_v1_shift;
    logic       r_v1_overwrite, w_nxt_v1_overwrite;
    logic       r_v1_load_ans, w_nxt_v1_load_ans;
    logic       r_v2_load,     w_nxt_v2_load;
    logic       r_regs_clear,  w_nxt_regs_clear;
    logic [3:0] r_hex_out,     w_nxt_hex_out;
    logic       r_alu_start,   w_nxt_alu_start;
    op_t        r_alu_op,      w_nxt_alu_op;
    logic       r_busy,        w_nxt_busy;
    logic       r_error,       w_nxt_error;

    // Keypad events after priority masking: only the strongest one survives.
    logic w_ev_clr, w_ev_eq, w_ev_op, w_ev_hex, w_room, w_expired;
    assign w_ev_clr = bus.clr;
    assign w_ev_eq  = bus.eq & ~bus.clr;
    assign w_ev_op  = bus.newop & ~bus.eq & ~bus.clr;
    assign w_ev_hex = bus.newhex & ~bus.newop & ~bus.eq & ~bus.clr;
    assign w_room   = (r_digit_cnt < MAXD);

    calc_watchdog #(.CNT_W(CNT_W), .ALU_TIMEOUT(ALU_TIMEOUT)) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_nxt_alu_start),
        .i_run     (r_state == CALC),
        .o_expired (w_expired)
    );

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= SHOW;
            r_pend_op      <= OP_ADD;
            r_pend_valid   <= 1'b0;
            r_chain_op     <= OP_ADD;
            r_chain_valid  <= 1'b0;
            r_digit_cnt    <= 3'd0;
            r_v1_shift     <= 1'b0;
            r_v1_overwrite <= 1'b0;
            r_v1_load_ans  <= 1'b0;
            r_v2_load      <= 1'b0;
            r_regs_clear   <= 1'b0;
            r_hex_out      <= 4'd0;
            r_alu_start    <= 1'b0;
            r_alu_op       <= OP_ADD;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_nxt_state;
            r_pend_op      <= w_nxt_pend_op;
            r_pend_valid   <= w_nxt_pend_valid;
            r_chain_op     <= w_nxt_chain_op;
            r_chain_valid  <= w_nxt_chain_valid;
            r_digit_cnt    <= w_nxt_digit_cnt;
            r_v1_shift     <= w_nxt_v1_shift;
            r_v1_overwrite <= w_nxt_v1_overwrite;
            r_v1_load_ans  <= w_nxt_v1_load_ans;
            r_v2_load      <= w_nxt_v2_load;
            r_regs_clear   <= w_nxt_regs_clear;
            r_hex_out      <= w_nxt_hex_out;
            r_alu_start    <= w_nxt_alu_start;
            r_alu_op       <= w_nxt_alu_op;
            r_busy         <= w_nxt_busy;
            r_error        <= w_nxt_error;
        end
    end

    // Next state plus pending-operator, chain and digit-count tracking.
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_pend_op     = r_pend_op;
        w_nxt_pend_valid  = r_pend_valid;
        w_nxt_chain_op    = r_chain_op;
        w_nxt_chain_valid = r_chain_valid;
        w_nxt_digit_cnt   = r_digit_cnt;
        if (w_ev_clr) begin
            w_nxt_state       = SHOW;
            w_nxt_digit_cnt   = 3'd0;
            w_nxt_pend_valid  = 1'b0;
            w_nxt_chain_valid = 1'b0;
        end else begin
            case (r_state)
                SHOW: begin
                    if (w_ev_op) begin
                        w_nxt_pend_op    = bus.opcode;
                        w_nxt_pend_valid = 1'b1;
                        w_nxt_state      = OPWAIT;
                    end else if (w_ev_hex) begin
                        w_nxt_digit_cnt = 3'd1;
                        w_nxt_state     = ENTRY;
                    end
                end
                ENTRY: begin
                    if (w_ev_eq) begin
                        if (r_pend_valid) w_nxt_state = CALC;
                    end else if (w_ev_op) begin
                        if (r_pend_valid) begin
                            w_nxt_chain_op    = bus.opcode;
                            w_nxt_chain_valid = 1'b1;
                            w_nxt_state       = CALC;
                        end else begin
                            w_nxt_pend_op    = bus.opcode;
                            w_nxt_pend_valid = 1'b1;
                            w_nxt_state      = OPWAIT;
                        end
                    end else if (w_ev_hex && w_room) begin
                        w_nxt_digit_cnt = r_digit_cnt + 3'd1;
                    end
                end
                OPWAIT: begin
                    if (w_ev_eq) begin
                        w_nxt_state = CALC;
                    end else if (w_ev_op) begin
                        w_nxt_pend_op = bus.opcode;
                    end else if (w_ev_hex) begin
                        w_nxt_digit_cnt = 3'd1;
                        w_nxt_state     = ENTRY;
                    end
                end
                CALC: begin
                    // A real result wins over a coincident timeout.
                    if (bus.alu_done) begin
                        if (bus.alu_ovf) begin
                            w_nxt_state = ERR;
                        end else begin
                            w_nxt_digit_cnt = 3'd0;
                            if (r_chain_valid) begin
                                w_nxt_state = CHAIN;
                            end else begin
                                w_nxt_pend_valid = 1'b0;
                                w_nxt_state      = SHOW;
                            end
                        end
                    end else if (w_expired) begin
                        w_nxt_state = ERR;
                    end
                end
                CHAIN: begin
                    w_nxt_pend_op     = r_chain_op;
                    w_nxt_chain_valid = 1'b0;
                    w_nxt_state       = OPWAIT;
                end
                ERR:     w_nxt_state = ERR;
                default: w_nxt_state = SHOW;
            endcase
        end
    end

    // Next values of the registered strobes, operator and status outputs.
    always_comb begin
        w_nxt_v1_shift     = 1'b0;
        w_nxt_v1_overwrite = 1'b0;
        w_nxt_v1_load_ans  = 1'b0;
        w_nxt_v2_load      = 1'b0;
        w_nxt_regs_clear   = 1'b0;
        w_nxt_alu_start    = 1'b0;
        w_nxt_hex_out      = r_hex_out;
        w_nxt_alu_op       = r_alu_op;
        if (w_ev_clr) begin
            w_nxt_regs_clear = 1'b1;
        end else begin
            case (r_state)
                SHOW: begin
                    if (w_ev_op) begin
                        w_nxt_v2_load = 1'b1;
                    end else if (w_ev_hex) begin
                        w_nxt_v1_overwrite = 1'b1;
                        w_nxt_hex_out      = bus.hexcode;
                    end
                end
                ENTRY: begin
                    if (w_ev_eq || w_ev_op) begin
                        if (r_pend_valid) begin
                            w_nxt_alu_start = 1'b1;
                            w_nxt_alu_op    = r_pend_op;
                        end else if (w_ev_op) begin
                            w_nxt_v2_load = 1'b1;
                        end
                    end else if (w_ev_hex && w_room) begin
                        w_nxt_v1_shift = 1'b1;
                        w_nxt_hex_out  = bus.hexcode;
                    end
                end
                OPWAIT: begin
                    if (w_ev_eq) begin
                        w_nxt_alu_start = 1'b1;
                        w_nxt_alu_op    = r_pend_op;
                    end else if (w_ev_hex) begin
                        w_nxt_v1_overwrite = 1'b1;
                        w_nxt_hex_out      = bus.hexcode;
                    end
                end
                CALC:    w_nxt_v1_load_ans = bus.alu_done & ~bus.alu_ovf;
                CHAIN:   w_nxt_v2_load = 1'b1;
                default: ;
            endcase
        end
        w_nxt_busy  = (w_nxt_state == CALC) || (w_nxt_state == CHAIN);
        w_nxt_error = (w_nxt_state == ERR);
    end

    assign bus.v1_shift     = r_v1_shift;
    assign bus.v1_overwrite = r_v1_overwrite;
    assign bus.v1_load_ans  = r_v1_load_ans;
    assign bus.v2_load      = r_v2_load;
    assign bus.regs_clear   = r_regs_clear;
    assign bus.hex_out      = r_hex_out;
    assign bus.alu_start    = r_alu_start;
    assign bus.alu_op       = r_alu_op;
    assign bus.busy         = r_busy;
    assign bus.error        = r_error;
    assign bus.digit_cnt    = r_digit_cnt;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: vector table, hand-written corner sequences and
// a randomized run against a flag-based behavioural model.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int TIMEOUT = 64;
    localparam int MAXD    = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    calc_sequencer_if bus();

    calc_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       hx;
        logic [3:0] code;
        logic       op;
        logic [1:0] opc;
        logic       eq;
        logic       clr;
        logic       done;
        logic       ovf;
    } in_t;

    typedef struct packed {
        logic       sh;
        logic       ow;
        logic       ans;
        logic       v2;
        logic       cl;
        logic [3:0] hex;
        logic       st;
        logic [1:0] aop;
        logic       busy;
        logic       err;
        logic [2:0] cnt;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: operand-level flags rather than named states.
    bit         m_err, m_calc, m_chainstep, m_flow, m_pend, m_chain;
    int         m_digits, m_wd;
    logic [1:0] m_pend_op, m_chain_op, m_alu_op;
    logic [3:0] m_hex;
    out_t       m_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.sh   = bus.v1_shift;
        o.ow   = bus.v1_overwrite;
        o.ans  = bus.v1_load_ans;
        o.v2   = bus.v2_load;
        o.cl   = bus.regs_clear;
        o.hex  = bus.hex_out;
        o.st   = bus.alu_start;
        o.aop  = bus.alu_op;
        o.busy = bus.busy;
        o.err  = bus.error;
        o.cnt  = bus.digit_cnt;
        return o;
    endfunction

    function automatic in_t IDLE();
        in_t x = '0;
        return x;
    endfunction
    function automatic in_t H(input int c);
        in_t x = '0;
        x.hx = 1'b1; x.code = 4'(c);
        return x;
    endfunction
    function automatic in_t OP(input int c);
        in_t x = '0;
        x.op = 1'b1; x.opc = 2'(c);
        return x;
    endfunction
    function automatic in_t EQ();
        in_t x = '0;
        x.eq = 1'b1;
        return x;
    endfunction
    function automatic in_t CLR();
        in_t x = '0;
        x.clr = 1'b1;
        return x;
    endfunction
    function automatic in_t DONE(input int ovf);
        in_t x = '0;
        x.done = 1'b1; x.ovf = 1'(ovf);
        return x;
    endfunction

    function automatic out_t O(input int sh, ow, ans, v2, cl, hex, st, aop, busy, err, cnt);
        out_t o;
        o.sh = 1'(sh); o.ow = 1'(ow); o.ans = 1'(ans); o.v2 = 1'(v2); o.cl = 1'(cl);
        o.hex = 4'(hex); o.st = 1'(st); o.aop = 2'(aop);
        o.busy = 1'(busy); o.err = 1'(err); o.cnt = 3'(cnt);
        return o;
    endfunction

    task automatic model_reset();
        m_err = 0; m_calc = 0; m_chainstep = 0; m_flow = 1; m_pend = 0; m_chain = 0;
        m_digits = 0; m_wd = 0; m_pend_op = 0; m_chain_op = 0; m_alu_op = 0; m_hex = 0;
        m_exp = '0;
    endtask

    task automatic model_step(input in_t x);
        bit sh = 0, ow = 0, ans = 0, v2 = 0, cl = 0, st = 0;
        if (x.clr) begin
            cl = 1; m_digits = 0; m_pend = 0; m_chain = 0; m_err = 0;
            m_calc = 0; m_chainstep = 0; m_flow = 1;
        end else if (m_err) begin
            // only clear gets out of an error
        end else if (m_chainstep) begin
            v2 = 1; m_pend_op = m_chain_op; m_chain = 0; m_flow = 1; m_chainstep = 0;
        end else if (m_calc) begin
            if (x.done) begin
                m_calc = 0;
                if (x.ovf) m_err = 1;
                else begin
                    ans = 1; m_digits = 0; m_flow = 1;
                    if (m_chain) m_chainstep = 1;
                    else m_pend = 0;
                end
            end else begin
                m_wd++;
                if (m_wd >= TIMEOUT) begin m_calc = 0; m_err = 1; end
            end
        end else if (x.eq) begin
            if (m_pend) begin st = 1; m_alu_op = m_pend_op; m_calc = 1; m_wd = 0; end
        end else if (x.op) begin
            if (!m_pend) begin
                v2 = 1; m_pend = 1; m_pend_op = x.opc; m_flow = 1;
            end else if (m_flow) begin
                m_pend_op = x.opc;
            end else begin
                st = 1; m_alu_op = m_pend_op; m_chain_op = x.opc; m_chain = 1;
                m_calc = 1; m_wd = 0;
            end
        end else if (x.hx) begin
            if (m_flow) begin
                ow = 1; m_hex = x.code; m_digits = 1; m_flow = 0;
            end else if (m_digits < MAXD) begin
                sh = 1; m_hex = x.code; m_digits++;
            end
        end
        m_exp = O(sh, ow, ans, v2, cl, m_hex, st, m_alu_op, m_calc || m_chainstep, m_err, m_digits);
    endtask

    task automatic step(input in_t x);
        @(negedge clock);
        bus.newhex = x.hx; bus.hexcode = x.code; bus.newop = x.op; bus.opcode = x.opc;
        bus.eq = x.eq; bus.clr = x.clr; bus.alu_done = x.done; bus.alu_ovf = x.ovf;
        model_step(x);
        @(posedge clock);
        #1;
    endtask

    vec_t tbl[23];
    out_t o;
    in_t  x;
    int   early;

    initial begin
        bus.newhex = 0; bus.hexcode = 0; bus.newop = 0; bus.opcode = 0;
        bus.eq = 0; bus.clr = 0; bus.alu_done = 0; bus.alu_ovf = 0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset", dut_out(), '0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // digits: first overwrites, then shifts, fifth ignored
        tbl[0]  = '{H(1),  O(0,1,0,0,0,1,0,0,0,0,1)};
        tbl[1]  = '{H(2),  O(1,0,0,0,0,2,0,0,0,0,2)};
        tbl[2]  = '{H(3),  O(1,0,0,0,0,3,0,0,0,0,3)};
        tbl[3]  = '{H(4),  O(1,0,0,0,0,4,0,0,0,0,4)};
        tbl[4]  = '{H(5),  O(0,0,0,0,0,4,0,0,0,0,4)};
        tbl[5]  = '{IDLE(), O(0,0,0,0,0,4,0,0,0,0,4)};
        tbl[6]  = '{CLR(), O(0,0,0,0,1,4,0,0,0,0,0)};
        // 1 2 ADD 3 = with a two-cycle ALU
        tbl[7]  = '{H(1),  O(0,1,0,0,0,1,0,0,0,0,1)};
        tbl[8]  = '{H(2),  O(1,0,0,0,0,2,0,0,0,0,2)};
        tbl[9]  = '{OP(OP_ADD), O(0,0,0,1,0,2,0,0,0,0,2)};
        tbl[10] = '{H(3),  O(0,1,0,0,0,3,0,0,0,0,1)};
        tbl[11] = '{EQ(),  O(0,0,0,0,0,3,1,0,1,0,1)};
        tbl[12] = '{IDLE(), O(0,0,0,0,0,3,0,0,1,0,1)};
        tbl[13] = '{DONE(0), O(0,0,1,0,0,3,0,0,0,0,0)};
        tbl[14] = '{EQ(),  O(0,0,0,0,0,3,0,0,0,0,0)};
        // simultaneous events
        tbl[15] = '{H(7),  O(0,1,0,0,0,7,0,0,0,0,1)};
        x = H(9); x.op = 1'b1; x.opc = OP_SUB;
        tbl[16] = '{x,     O(0,0,0,1,0,7,0,0,0,0,1)};
        x = H(5); x.clr = 1'b1;
        tbl[17] = '{x,     O(0,0,0,0,1,7,0,0,0,0,0)};
        tbl[18] = '{DONE(0), O(0,0,0,0,0,7,0,0,0,0,0)};
        // SHOW operator, OPWAIT re-select, then equals
        tbl[19] = '{OP(OP_MUL), O(0,0,0,1,0,7,0,0,0,0,0)};
        tbl[20] = '{OP(OP_AND), O(0,0,0,0,0,7,0,0,0,0,0)};
        tbl[21] = '{EQ(),  O(0,0,0,0,0,7,1,3,1,0,0)};
        tbl[22] = '{CLR(), O(0,0,0,0,1,7,0,3,0,0,0)};

        for (int k = 0; k < 23; k++) begin
            step(tbl[k].i);
            chk($sformatf("vec%0d", k), dut_out(), tbl[k].o);
        end

        // chain: 5 ADD 3 SUB
        step(H(5)); step(OP(OP_ADD)); step(H(3)); step(OP(OP_SUB));
        o = dut_out(); chk("chain_start", {o.st, o.aop, o.busy}, 4'b1001);
        step(IDLE()); step(DONE(0));
        o = dut_out(); chk("chain_ans", {o.ans, o.v2, o.busy}, 3'b101);
        step(IDLE());
        o = dut_out(); chk("chain_v2", {o.ans, o.v2, o.busy}, 3'b010);
        step(EQ());
        o = dut_out(); chk("chain_pend_sub", {o.st, o.aop}, 3'b101);
        step(DONE(0));
        o = dut_out(); chk("chain_end", {o.ans, o.v2, o.busy}, 3'b100);

        // overflow
        step(H(1)); step(OP(OP_MUL)); step(H(2)); step(EQ());
        o = dut_out(); chk("ovf_start", {o.st, o.aop}, 3'b110);
        step(DONE(1));
        o = dut_out(); chk("ovf_err", {o.err, o.ans, o.busy}, 3'b100);
        step(H(4)); step(EQ());
        o = dut_out(); chk("err_hold", {o.err, o.sh, o.ow, o.st}, 4'b1000);
        step(CLR());
        o = dut_out(); chk("err_clr", {o.err, o.cl}, 2'b01);

        // watchdog timeout
        step(H(1)); step(OP(OP_AND)); step(H(2)); step(EQ());
        o = dut_out(); chk("to_start", {o.st, o.aop}, 3'b111);
        early = 0;
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            step(IDLE());
            if (bus.error !== 1'b0) early++;
        end
        chk("to_early", early, 0);
        step(IDLE());
        o = dut_out(); chk("to_err", {o.err, o.busy}, 2'b10);
        step(DONE(0));
        o = dut_out(); chk("to_late_done", {o.ans, o.err}, 2'b01);
        step(CLR());

        // clear while the ALU is working
        step(H(1)); step(OP(OP_ADD)); step(H(2)); step(EQ()); step(IDLE());
        step(CLR());
        o = dut_out(); chk("calc_clr", {o.cl, o.busy, o.cnt}, 5'b10000);
        step(DONE(0));
        o = dut_out(); chk("calc_clr_done", {o.ans, o.v2}, 2'b00);

        // randomized run against the model
        for (int k = 0; k < 800; k++) begin
            x = '0;
            x.clr  = ($urandom_range(0, 39) == 0);
            x.eq   = ($urandom_range(0, 5) == 0);
            x.op   = ($urandom_range(0, 4) == 0);
            x.hx   = ($urandom_range(0, 2) == 0);
            x.code = 4'($urandom);
            x.opc  = 2'($urandom);
            if (m_calc) x.done = ($urandom_range(0, 3) == 0);
            else        x.done = ($urandom_range(0, 29) == 0);
            x.ovf  = x.done && ($urandom_range(0, 7) == 0);
            step(x);
            chk($sformatf("rand%0d", k), dut_out(), m_exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
